adder16_arb: RTL

- Round-robin arbiter and sequencer that shares one registered 16-bit adder stage among NREQ requesters.
- Per request: grants one requester, captures its operands into the adder's operand registers, and returns {cout, sum} tagged with the requester id.
- Output has a valid/ready handshake with backpressure.
- Optional per-requester carry chaining lets a requester run multi-word (multi-precision) additions 16 bits per request.

---
 rtl/adder16_arb.sv | 101 ++++++++++
 1 files changed

// File: rtl/adder16_arb.sv
// Round-robin arbiter sharing one registered adder stage among NREQ requesters.
// Results leave through a valid/ready port; per-requester carries allow multi-word adds.
module adder16_arb #(
   parameter int NREQ  = 4,
   parameter int IDW   = 2,
   parameter int WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ-1:0]       chain,
   input  logic [NREQ*WIDTH-1:0] x_flat,
   input  logic [NREQ*WIDTH-1:0] y_flat,
   input  logic [NREQ-1:0]       cin,
   output logic [NREQ-1:0]       gnt,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      sum,
   output logic                  cout
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state, state_next;
   logic [IDW-1:0]   ptr;
   logic [IDW-1:0]   g;
   logic [IDW-1:0]   idx;
   logic             found;
   logic             accept;
   logic             drain;
   logic [WIDTH-1:0] r0, r1;
   logic             rc;
   logic             carry_sel;
   logic [NREQ-1:0]  carry_q;
   logic [WIDTH:0]   total;

   assign rsp_valid = (state == FULL);
   assign drain     = rsp_valid && rsp_ready;
   assign accept    = !reset && (|req) && (!rsp_valid || rsp_ready);

   // First requesting index at or after ptr; NREQ is a power of two so idx wraps naturally.
   always_comb begin
      g     = ptr;
      idx   = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = ptr + IDW'(k);
         if (!found && req[idx]) begin
            g     = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (accept) gnt[g] = 1'b1;
   end

   // A chained request issued while its own previous word drains takes the live cout.
   always_comb begin
      carry_sel = cin[g];
      if (chain[g]) carry_sel = (drain && (rsp_id == g)) ? cout : carry_q[g];
   end

   assign total       = {1'b0, r0} + {1'b0, r1} + {{WIDTH{1'b0}}, rc};
   assign {cout, sum} = total;

   always_comb begin
      state_next = state;
      if (accept)     state_next = FULL;
      else if (drain) state_next = EMPTY;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= EMPTY;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r0      <= '0;
         r1      <= '0;
         rc      <= 1'b0;
         rsp_id  <= '0;
         ptr     <= '0;
         carry_q <= '0;
      end else begin
         if (drain) carry_q[rsp_id] <= cout;
         if (accept) begin
            r0     <= x_flat[g*WIDTH +: WIDTH];
            r1     <= y_flat[g*WIDTH +: WIDTH];
            rc     <= carry_sel;
            rsp_id <= g;
            ptr    <= g + IDW'(1);
         end
      end
   end

endmodule
